// File: rtl/pipe_stage_latch.sv
// Two-entry elastic pipeline register (main + skid) with flush and a
// saturating backpressure counter. Handshake outputs come straight from
// flops, so in_ready and out_valid do not depend combinationally on any input.
module pipe_stage_latch #(
  parameter int unsigned     W      = 32,
  parameter int unsigned     NF     = 3,
  parameter logic [W-1:0]    NOP_IR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NF*W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NF*W-1:0]   out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned DW = NF * W;
  localparam logic [DW-1:0] NOP_ENTRY = DW'(NOP_IR);
  localparam logic [15:0]   STALL_MAX = 16'hFFFF;

  // State bits double as the handshake flags: [1] = out_valid, [0] = in_ready.
  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    ONE   = 2'b11,
    FULL  = 2'b10
  } state_t;

  state_t          state;
  logic [DW-1:0]   main_q;
  logic [DW-1:0]   skid_q;
  logic            in_xfer;
  logic            out_xfer;

  assign out_valid = state[1];
  assign in_ready  = state[0];
  assign out_data  = main_q;

  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;

  // Occupancy FSM and entry storage; reset beats flush, flush beats transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      occupancy <= 2'd0;
      main_q    <= NOP_ENTRY;
      skid_q    <= NOP_ENTRY;
    end else if (flush) begin
      state     <= EMPTY;
      occupancy <= 2'd0;
      main_q    <= NOP_ENTRY;
      skid_q    <= NOP_ENTRY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state     <= ONE;
            occupancy <= 2'd1;
            main_q    <= in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (out_xfer) begin
            state     <= EMPTY;
            occupancy <= 2'd0;
          end else if (in_xfer) begin
            state     <= FULL;
            occupancy <= 2'd2;
            skid_q    <= in_data;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state     <= ONE;
            occupancy <= 2'd1;
            main_q    <= skid_q;
          end
        end
        default: begin
          state     <= EMPTY;
          occupancy <= 2'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the head entry is held by backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch (W=32, NF=3) with immediate assertions.
module tb_pipe_stage_latch;

  localparam int unsigned W  = 32;
  localparam int unsigned NF = 3;
  localparam logic [W-1:0] NOP = 32'h0000_0013;
  localparam logic [NF*W-1:0] NOP_E = {32'h0, 32'h0, NOP};

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [NF*W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [NF*W-1:0] out_data;
  logic [1:0]      occupancy;
  logic [15:0]     stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_latch #(.W(W), .NF(NF), .NOP_IR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NF*W-1:0] pk(input logic [W-1:0] ir, input logic [W-1:0] o,
                                         input logic [W-1:0] d);
    return {d, o, ir};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NF*W-1:0] a_e, b_e, c_e, d_e, e_e;

  initial begin
    a_e = pk(32'hA1, 32'hA2, 32'hA3);
    b_e = pk(32'hB1, 32'hB2, 32'hB3);
    c_e = pk(32'hC1, 32'hC2, 32'hC3);
    d_e = pk(32'hD1, 32'hD2, 32'hD3);
    e_e = pk(32'hE1, 32'hE2, 32'hE3);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_in_ready",  96'(in_ready),  96'd1);
    chk("rst_occ",       96'(occupancy), 96'd0);
    chk("rst_stall",     96'(stall_cnt), 96'd0);
    chk("rst_data",      out_data,       NOP_E);

    // Streaming with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; in_data = pk(32'd1, 32'd2, 32'd3);
    tick();
    chk("str1_valid", 96'(out_valid), 96'd1);
    chk("str1_data",  out_data,       pk(32'd1, 32'd2, 32'd3));
    chk("str1_occ",   96'(occupancy), 96'd1);
    in_data = pk(32'd4, 32'd5, 32'd6);
    tick();
    chk("str2_data",  out_data,       pk(32'd4, 32'd5, 32'd6));
    chk("str2_occ",   96'(occupancy), 96'd1);
    in_valid = 1'b0;
    tick();
    chk("str_drain_occ",   96'(occupancy), 96'd0);
    chk("str_drain_valid", 96'(out_valid), 96'd0);
    chk("str_stall",       96'(stall_cnt), 96'd0);

    // Backpressure: fill both entries, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = a_e;
    tick();
    chk("bp1_occ",  96'(occupancy), 96'd1);
    chk("bp1_data", out_data,       a_e);
    in_data = b_e;
    tick();
    chk("bp2_occ",   96'(occupancy), 96'd2);
    chk("bp2_ready", 96'(in_ready),  96'd0);
    chk("bp2_data",  out_data,       a_e);
    chk("bp2_stall", 96'(stall_cnt), 96'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp3_data", out_data,       b_e);
    chk("bp3_occ",  96'(occupancy), 96'd1);
    tick();
    chk("bp4_occ",   96'(occupancy), 96'd0);
    chk("bp4_stall", 96'(stall_cnt), 96'd1);

    // Flush while FULL with a simultaneous incoming entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = c_e;
    tick();
    in_data = d_e;
    tick();
    chk("fl_pre_occ",   96'(occupancy), 96'd2);
    chk("fl_pre_stall", 96'(stall_cnt), 96'd2);
    flush = 1'b1; in_data = e_e;
    tick();
    chk("fl_valid", 96'(out_valid), 96'd0);
    chk("fl_occ",   96'(occupancy), 96'd0);
    chk("fl_ready", 96'(in_ready),  96'd1);
    chk("fl_data",  out_data,       NOP_E);
    chk("fl_stall", 96'(stall_cnt), 96'd3);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_post_occ",   96'(occupancy), 96'd0);
    chk("fl_post_stall", 96'(stall_cnt), 96'd3);

    // Saturation: one held entry under constant backpressure
    in_valid = 1'b1; in_data = a_e;
    tick();
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall", 96'(stall_cnt), 96'hFFFF);
    chk("sat_data",  out_data,       a_e);
    tick(); tick();
    chk("sat_nowrap", 96'(stall_cnt), 96'hFFFF);

    // Reset while FULL with flush asserted and stall_cnt at 100
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_clear_stall", 96'(stall_cnt), 96'd0);
    in_valid = 1'b1; in_data = b_e;
    tick();
    in_data = c_e;
    tick();
    in_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("rs_pre_stall", 96'(stall_cnt), 96'd100);
    chk("rs_pre_occ",   96'(occupancy), 96'd2);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = d_e;
    tick();
    chk("rs_occ",   96'(occupancy), 96'd0);
    chk("rs_ready", 96'(in_ready),  96'd1);
    chk("rs_valid", 96'(out_valid), 96'd0);
    chk("rs_stall", 96'(stall_cnt), 96'd0);
    chk("rs_data",  out_data,       NOP_E);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("rs_post_occ", 96'(occupancy), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 SHALL have parameter W, default 32: width of one field, in bits.
REQ-002 SHALL have parameter NF, default 3: number of fields carried (field 0 = IR, 1 = O, 2 = D).
REQ-003 SHALL have parameter NOP_IR, default 32'h00000000: value loaded into field 0 on reset and flush; width W.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream has data this cycle.
REQ-008 in_ready  output  1  stage can accept data; driven from state only.
REQ-009 in_data  input  NF*W  packed fields; field k = bits [k*W+W-1 : k*W].
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  NF*W  head entry, same packing as in_data.
REQ-013 occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 stall_cnt  output  16  count of backpressure cycles.

Function
REQ-015 SHALL define input transfer as in_valid && in_ready && !flush, and output transfer as out_valid && out_ready.
REQ-016 SHALL hold two registered entries: MAIN (drives out_data) and SKID.
REQ-017 SHALL implement states EMPTY (0 entries), ONE (MAIN valid) and FULL (MAIN and SKID valid); occupancy = 0/1/2 respectively.
REQ-018 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), with no combinational path from out_ready or in_valid.
REQ-019 EMPTY: input transfer -> ONE, MAIN <= in_data; otherwise stay EMPTY.
REQ-020 ONE: input and output transfer -> ONE, MAIN <= in_data; output only -> EMPTY; input only -> FULL, SKID <= in_data; neither -> ONE, MAIN unchanged.
REQ-021 FULL: output transfer -> ONE, MAIN <= SKID; otherwise stay FULL with MAIN and SKID unchanged.
REQ-022 SHALL preserve entry order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-023 SHALL sustain one transfer per cycle when out_ready is held high, with latency of 1 cycle from input transfer to out_valid.
REQ-024 flush SHALL move the state to EMPTY on the next edge, overriding any simultaneous input or output transfer in that cycle.
REQ-025 flush SHALL load MAIN and SKID field 0 with NOP_IR and all other fields with 0.
REQ-026 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, and SHALL saturate at 16'hFFFF.
REQ-027 stall_cnt SHALL be unaffected by flush.
REQ-028 Each field's value SHALL pass through the stage unmodified; fields SHALL be independent of one another.

Reset
REQ-029 reset SHALL take priority over flush and all transfers.
REQ-030 On reset the block SHALL enter EMPTY, giving out_valid=0, in_ready=1, occupancy=0 and stall_cnt=0.
REQ-031 On reset out_data field 0 SHALL be NOP_IR and all other fields 0; SKID SHALL be cleared the same way.
REQ-032 Reset asserted while the stage is FULL SHALL discard both entries within one cycle.

Verification (W=32, NF=3)
REQ-033 Streaming: out_ready=1, push {D,O,IR}={3,2,1}, then {6,5,4}, on consecutive cycles -> out_data equals each entry one cycle later; occupancy stays at 1.
REQ-034 Backpressure: out_ready=0, push A and then B -> occupancy=2, in_ready=0, out_data=A; raise out_ready -> A out, then B out, then occupancy=0.
REQ-035 Flush while FULL with in_valid=1 -> next cycle out_valid=0, field 0 = NOP_IR, incoming entry discarded, stall_cnt unchanged.
REQ-036 Saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-037 Reset while FULL with flush=1 and stall_cnt=100 -> occupancy=0, in_ready=1, stall_cnt=0.
REQ-038 Simultaneous events in ONE (input and output transfer in the same cycle) -> state remains ONE and MAIN holds the new entry.
